// File: rtl/rotary_pkg.sv
// Shared constants for the rotary encoder front end: quadrature state
// encodings (equal to the debounced {A,B} pin pair), direction codes and
// the sizing helper for the debounce counters.
package rotary_pkg;

  localparam logic [1:0] ST_00 = 2'b00;
  localparam logic [1:0] ST_01 = 2'b01;
  localparam logic [1:0] ST_11 = 2'b11;
  localparam logic [1:0] ST_10 = 2'b10;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  // Width needed to hold a count of 0..deb_cycles.
  function automatic int deb_cnt_w(input int deb_cycles);
    return $clog2(deb_cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchroniser followed by a stable-count filter. The output only
// follows the synchronised input after it has differed from the current
// output for DEB_CYCLES consecutive clocks, so shorter glitches are dropped.
module debounce_filter
  import rotary_pkg::*;
#(
  parameter int DEB_CYCLES = 5000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int CW = deb_cnt_w(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic          sync1_r;
  logic          sync2_r;
  logic          deb_r;
  logic [CW-1:0] cnt_r;

  // Bring the asynchronous pin into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
    end
  end

  // Count consecutive disagreeing clocks; accept the new level on the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
      deb_r <= 1'b0;
    end else if (sync2_r == deb_r) begin
      cnt_r <= {CW{1'b0}};
      deb_r <= deb_r;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= {CW{1'b0}};
      deb_r <= sync2_r;
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
      deb_r <= deb_r;
    end
  end

  assign dout = deb_r;

endmodule

// File: rtl/rotary_step_decoder.sv
// Rotary encoder front end: debounces A, B and push, decodes one step per
// detent (counted on arrival at S11 after passing through S00), keeps a
// wrapping signed position count and produces a debounced push level/pulse.
module rotary_step_decoder
  import rotary_pkg::*;
#(
  parameter int DEB_CYCLES = 5000,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             enc_push,
  input  logic             pos_clr,
  output logic             step_valid,
  output logic             step_dir,
  output logic [CNT_W-1:0] position,
  output logic             push_level,
  output logic             push_pulse,
  output logic             err_pulse
);

  localparam logic [CNT_W-1:0] POS_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             deb_a_s;
  logic             deb_b_s;
  logic             deb_push_s;

  logic [1:0]       state_r;
  logic             armed_r;
  logic [1:0]       pin_state_s;
  logic [1:0]       state_diff_s;
  logic             armed_nxt_s;
  logic             step_s;
  logic             dir_s;
  logic             err_s;

  logic             step_valid_r;
  logic             step_dir_r;
  logic             err_r;
  logic [CNT_W-1:0] position_r;
  logic             push_level_r;
  logic             push_pulse_r;

  debounce_filter #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (enc_a),
    .dout  (deb_a_s)
  );

  debounce_filter #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (enc_b),
    .dout  (deb_b_s)
  );

  debounce_filter #(.DEB_CYCLES(DEB_CYCLES)) u_deb_push (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (enc_push),
    .dout  (deb_push_s)
  );

  // Quadrature decode: classify the change between registered and debounced state.
  always_comb begin
    pin_state_s  = {deb_a_s, deb_b_s};
    state_diff_s = pin_state_s ^ state_r;
    armed_nxt_s  = armed_r;
    step_s       = 1'b0;
    dir_s        = DIR_RIGHT;
    err_s        = 1'b0;
    case (state_diff_s)
      2'b00: begin
        armed_nxt_s = armed_r;
      end
      2'b11: begin
        // Both channels moved in one clock: direction is unknowable.
        err_s       = 1'b1;
        armed_nxt_s = 1'b0;
      end
      default: begin
        if (pin_state_s == ST_00) begin
          armed_nxt_s = 1'b1;
        end else if ((pin_state_s == ST_11) && armed_r) begin
          step_s      = 1'b1;
          armed_nxt_s = 1'b0;
          if (state_r == ST_01) begin
            dir_s = DIR_LEFT;
          end else if (state_r == ST_10) begin
            dir_s = DIR_RIGHT;
          end else begin
            dir_s = DIR_RIGHT;
          end
        end else begin
          armed_nxt_s = armed_r;
        end
      end
    endcase
  end

  // FSM state, arm flag and registered step/error events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_00;
      armed_r      <= 1'b1;
      step_valid_r <= 1'b0;
      step_dir_r   <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= pin_state_s;
      armed_r      <= armed_nxt_s;
      step_valid_r <= step_s;
      step_dir_r   <= step_s & dir_s;
      err_r        <= err_s;
    end
  end

  // Position counter; a clear takes priority over a coincident step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      position_r <= {CNT_W{1'b0}};
    end else if (pos_clr) begin
      position_r <= {CNT_W{1'b0}};
    end else if (step_s) begin
      if (dir_s == DIR_LEFT) begin
        position_r <= position_r - POS_ONE;
      end else begin
        position_r <= position_r + POS_ONE;
      end
    end else begin
      position_r <= position_r;
    end
  end

  // Push level and rising-edge pulse, registered together so they align.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_level_r <= 1'b0;
      push_pulse_r <= 1'b0;
    end else begin
      push_level_r <= deb_push_s;
      push_pulse_r <= deb_push_s & ~push_level_r;
    end
  end

  assign step_valid = step_valid_r;
  assign step_dir   = step_dir_r;
  assign err_pulse  = err_r;
  assign position   = position_r;
  assign push_level = push_level_r;
  assign push_pulse = push_pulse_r;

endmodule

// File: tb/tb_rotary_step_decoder.sv
// Self-checking bench for rotary_step_decoder (DEB_CYCLES=4, CNT_W=16).
// Expected events come from a Gray-index model: positions 00,10,11,01 are
// indices 0..3; +1 is clockwise, -1 counter-clockwise, +2 is illegal.
module tb_rotary_step_decoder;

  localparam int DEB = 4;
  localparam int LAT = DEB + 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enc_a, enc_b, enc_push, pos_clr;
  logic        step_valid, step_dir, push_level, push_pulse, err_pulse;
  logic [15:0] position;

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;

  typedef struct packed {
    int          cyc;
    int          kind;  // 0 right step, 1 left step, 2 error
    logic [15:0] pos;
  } ev_t;

  ev_t ev_q[$];
  ev_t exp_q[$];
  int  pp_q[$];

  int m_idx;
  int m_pos;
  bit m_armed;

  rotary_step_decoder #(.DEB_CYCLES(DEB), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enc_a      (enc_a),
    .enc_b      (enc_b),
    .enc_push   (enc_push),
    .pos_clr    (pos_clr),
    .step_valid (step_valid),
    .step_dir   (step_dir),
    .position   (position),
    .push_level (push_level),
    .push_pulse (push_pulse),
    .err_pulse  (err_pulse)
  );

  always #5 clk = ~clk;

  // Cycle counter (counts rising edges).
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled on the falling edge.
  always @(negedge clk) begin
    ev_t e;
    if (step_valid === 1'b1) begin
      e.cyc = cyc; e.kind = (step_dir === 1'b1) ? 1 : 0; e.pos = position;
      ev_q.push_back(e);
    end
    if (err_pulse === 1'b1) begin
      e.cyc = cyc; e.kind = 2; e.pos = position;
      ev_q.push_back(e);
    end
    if (push_pulse === 1'b1) pp_q.push_back(cyc);
  end

  function automatic logic [1:0] ab_of(input int idx);
    case (idx)
      0: return 2'b00;
      1: return 2'b10;
      2: return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_reset();
    m_idx = 0; m_armed = 1'b1; m_pos = 0;
  endtask

  // Drive a new pin pair, predict its event, then hold it.
  task automatic move_to(input int idx, input int hold);
    int  delta;
    ev_t e;
    {enc_a, enc_b} = ab_of(idx);
    delta = (idx - m_idx + 4) % 4;
    e.cyc = cyc + LAT;
    if (delta == 2) begin
      m_armed = 1'b0;
      e.kind = 2; e.pos = m_pos[15:0];
      exp_q.push_back(e);
    end else if (delta != 0) begin
      if (idx == 0) begin
        m_armed = 1'b1;
      end else if (idx == 2 && m_armed) begin
        m_pos = ((delta == 1) ? m_pos + 1 : m_pos - 1) & 32'hFFFF;
        e.kind = (delta == 1) ? 0 : 1; e.pos = m_pos[15:0];
        exp_q.push_back(e);
        m_armed = 1'b0;
      end
    end
    m_idx = idx;
    tick(hold);
  endtask

  task automatic test_reset();
    rst_n = 1'b1; enc_a = 1'b0; enc_b = 1'b0; enc_push = 1'b0; pos_clr = 1'b0;
    #2 rst_n = 1'b0;
    tick(3);
    n_cmp++;
    if ({step_valid, step_dir, err_pulse, push_pulse, push_level, position} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_in: outputs=%h required 0", {step_valid, step_dir, err_pulse, push_pulse, push_level, position});
    end
    rst_n = 1'b1;
    model_reset();
    ev_q.delete();
    tick(10);
    n_cmp++;
    if ({step_valid, step_dir, err_pulse, push_pulse, push_level, position} !== 21'd0 || ev_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_after: outputs=%h events=%0d required 0/0",
               {step_valid, step_dir, err_pulse, push_pulse, push_level, position}, ev_q.size());
    end
  endtask

  task automatic test_cw_detent();
    ev_q.delete(); exp_q.delete();
    move_to(1, 10); move_to(2, 10); move_to(3, 10); move_to(0, 12);
    n_cmp++;
    if (ev_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL cw_count: got %0d events required %0d", ev_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < ev_q.size()) begin
      n_cmp++;
      if (ev_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL cw_event%0d: got cyc=%0d kind=%0d pos=%h required cyc=%0d kind=%0d pos=%h",
                 i, ev_q[i].cyc, ev_q[i].kind, ev_q[i].pos, exp_q[i].cyc, exp_q[i].kind, exp_q[i].pos);
      end
    end
    n_cmp++;
    if (position !== 16'h0001) begin
      n_fail++; $display("FAIL cw_position: got %h required 0001", position);
    end
  endtask

  task automatic test_ccw_three();
    pos_clr = 1'b1; tick(1); pos_clr = 1'b0; m_pos = 0;
    ev_q.delete(); exp_q.delete();
    repeat (3) begin
      move_to(3, 10); move_to(2, 10); move_to(1, 10); move_to(0, 10);
    end
    tick(4);
    n_cmp++;
    if (ev_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL ccw_count: got %0d events required %0d", ev_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < ev_q.size()) begin
      n_cmp++;
      if (ev_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL ccw_event%0d: got cyc=%0d kind=%0d pos=%h required cyc=%0d kind=%0d pos=%h",
                 i, ev_q[i].cyc, ev_q[i].kind, ev_q[i].pos, exp_q[i].cyc, exp_q[i].kind, exp_q[i].pos);
      end
    end
    n_cmp++;
    if (position !== 16'hFFFD) begin
      n_fail++; $display("FAIL ccw_position: got %h required FFFD", position);
    end
  endtask

  task automatic test_bounce();
    int bad;
    ev_q.delete(); exp_q.delete();
    bad = 0;
    repeat (5) begin
      enc_a = 1'b1;
      repeat (3) begin tick(1); if (dut.u_deb_a.dout !== 1'b0) bad++; end
      enc_a = 1'b0;
      repeat (3) begin tick(1); if (dut.u_deb_a.dout !== 1'b0) bad++; end
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++; $display("FAIL bounce_deb_a: debounced A moved on %0d burst cycles, required 0", bad);
    end
    move_to(1, 10); move_to(2, 10); move_to(3, 10); move_to(0, 12);
    n_cmp++;
    if (ev_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL bounce_count: got %0d events required %0d", ev_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < ev_q.size()) begin
      n_cmp++;
      if (ev_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL bounce_event%0d: got cyc=%0d kind=%0d pos=%h required cyc=%0d kind=%0d pos=%h",
                 i, ev_q[i].cyc, ev_q[i].kind, ev_q[i].pos, exp_q[i].cyc, exp_q[i].kind, exp_q[i].pos);
      end
    end
  endtask

  task automatic test_illegal();
    int pos_before;
    ev_q.delete(); exp_q.delete();
    pos_before = m_pos;
    move_to(2, 10);
    n_cmp++;
    if (position !== pos_before[15:0] || step_valid !== 1'b0) begin
      n_fail++; $display("FAIL illegal_hold: pos=%h step=%b required pos=%h step=0", position, step_valid, pos_before[15:0]);
    end
    move_to(3, 10); move_to(0, 10); move_to(3, 10); move_to(2, 10);
    move_to(1, 10); move_to(0, 12);
    n_cmp++;
    if (ev_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL illegal_count: got %0d events required %0d", ev_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < ev_q.size()) begin
      n_cmp++;
      if (ev_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL illegal_event%0d: got cyc=%0d kind=%0d pos=%h required cyc=%0d kind=%0d pos=%h",
                 i, ev_q[i].cyc, ev_q[i].kind, ev_q[i].pos, exp_q[i].cyc, exp_q[i].kind, exp_q[i].pos);
      end
    end
  endtask

  task automatic test_wrap_clear();
    int c;
    force dut.position_r = 16'h7FFF;
    tick(2);
    release dut.position_r;
    m_pos = 32'h7FFF;
    tick(1);
    n_cmp++;
    if (position !== 16'h7FFF) begin
      n_fail++; $display("FAIL wrap_preload: got %h required 7FFF", position);
    end
    ev_q.delete(); exp_q.delete();
    move_to(1, 10); move_to(2, 10); move_to(3, 10); move_to(0, 12);
    n_cmp++;
    if (ev_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL wrap_count: got %0d events required %0d", ev_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < ev_q.size()) begin
      n_cmp++;
      if (ev_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL wrap_event%0d: got cyc=%0d kind=%0d pos=%h required cyc=%0d kind=%0d pos=%h",
                 i, ev_q[i].cyc, ev_q[i].kind, ev_q[i].pos, exp_q[i].cyc, exp_q[i].kind, exp_q[i].pos);
      end
    end
    n_cmp++;
    if (position !== 16'h8000) begin
      n_fail++; $display("FAIL wrap_position: got %h required 8000", position);
    end
    // Clear coincident with the step edge: count cleared, event still emitted.
    move_to(1, 10);
    {enc_a, enc_b} = 2'b11; c = cyc;
    tick(LAT - 1);
    pos_clr = 1'b1;
    tick(1);
    pos_clr = 1'b0;
    n_cmp++;
    if (step_valid !== 1'b1 || step_dir !== 1'b0 || position !== 16'h0000 || cyc != c + LAT) begin
      n_fail++;
      $display("FAIL clr_step: step=%b dir=%b pos=%h at +%0d required 1/0/0000 at +%0d",
               step_valid, step_dir, position, cyc - c, LAT);
    end
    m_idx = 2; m_armed = 1'b0; m_pos = 0;
    move_to(3, 10); move_to(0, 12);
  endtask

  task automatic test_random_walk();
    int r, nxt;
    ev_q.delete(); exp_q.delete();
    repeat (40) begin
      r = $urandom_range(0, 9);
      if (r == 0) nxt = (m_idx + 2) % 4;
      else if (r <= 5) nxt = (m_idx + 1) % 4;
      else nxt = (m_idx + 3) % 4;
      move_to(nxt, $urandom_range(5, 12));
    end
    while (m_idx != 0) move_to((m_idx + 3) % 4, 8);
    tick(8);
    n_cmp++;
    if (ev_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL random_count: got %0d events required %0d", ev_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < ev_q.size()) begin
      n_cmp++;
      if (ev_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL random_event%0d: got cyc=%0d kind=%0d pos=%h required cyc=%0d kind=%0d pos=%h",
                 i, ev_q[i].cyc, ev_q[i].kind, ev_q[i].pos, exp_q[i].cyc, exp_q[i].kind, exp_q[i].pos);
      end
    end
    n_cmp++;
    if (position !== m_pos[15:0]) begin
      n_fail++; $display("FAIL random_position: got %h required %h", position, m_pos[15:0]);
    end
  endtask

  task automatic test_push();
    int p, rel;
    logic exp_lvl;
    pp_q.delete();
    enc_push = 1'b1; p = cyc; rel = p + 20;
    for (int k = 1; k <= 35; k++) begin
      tick(1);
      if (k == 20) enc_push = 1'b0;
      exp_lvl = (cyc >= p + LAT) && (cyc < rel + LAT);
      n_cmp++;
      if (push_level !== exp_lvl) begin
        n_fail++; $display("FAIL push_level: cycle +%0d got %b required %b", cyc - p, push_level, exp_lvl);
      end
    end
    n_cmp++;
    if (pp_q.size() != 1 || pp_q[0] != p + LAT) begin
      n_fail++;
      $display("FAIL push_pulse: got %0d pulses first at +%0d required 1 at +%0d",
               pp_q.size(), (pp_q.size() > 0) ? pp_q[0] - p : -1, LAT);
    end
  endtask

  task automatic test_reset_mid();
    int m;
    logic exp_lvl;
    enc_push = 1'b1;
    move_to(1, 10);
    tick(4);
    n_cmp++;
    if (push_level !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre_level: got %b required 1", push_level);
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({step_valid, step_dir, err_pulse, push_pulse, push_level, position} !== 21'd0) begin
      n_fail++;
      $display("FAIL mid_async_clear: outputs=%h required 0", {step_valid, step_dir, err_pulse, push_pulse, push_level, position});
    end
    {enc_a, enc_b} = 2'b00;
    model_reset();
    tick(3);
    pp_q.delete(); ev_q.delete();
    rst_n = 1'b1; m = cyc;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      exp_lvl = (cyc >= m + LAT);
      n_cmp++;
      if (push_level !== exp_lvl) begin
        n_fail++; $display("FAIL mid_level: cycle +%0d got %b required %b", cyc - m, push_level, exp_lvl);
      end
    end
    n_cmp++;
    if (pp_q.size() != 1 || pp_q[0] != m + LAT || ev_q.size() != 0) begin
      n_fail++;
      $display("FAIL mid_pulse: got %0d pulses first at +%0d, %0d step events; required 1 at +%0d, 0 events",
               pp_q.size(), (pp_q.size() > 0) ? pp_q[0] - m : -1, ev_q.size(), LAT);
    end
    enc_push = 1'b0;
    tick(12);
  endtask

  initial begin
    test_reset();
    test_cw_detent();
    test_ccw_three();
    test_bounce();
    test_illegal();
    test_wrap_clear();
    test_random_walk();
    test_push();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/rotary_step_decoder.md
# rotary_step_decoder

Input conditioner and quadrature decoder for the rotary-encoder front end. It synchronises and debounces the raw encoder pins A and B and the push button, decodes one step per detent with direction, and keeps a signed position count. The LED-rotation stage downstream consumes its single-cycle `step_valid`/`step_dir` events and its debounced push level in place of raw pin sampling.

## Interface
- `DEB_CYCLES`, default 5000: consecutive stable clocks required before a debounced input changes. Legal range is 1 to 2^20.
- `CNT_W`, default 16: width of the signed position counter.

- `clk`  in  1  system clock. All logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `enc_a`  in  1  raw encoder channel A, asynchronous to `clk`.
- `enc_b`  in  1  raw encoder channel B, asynchronous to `clk`.
- `enc_push`  in  1  raw push button, active-high, asynchronous.
- `pos_clr`  in  1  synchronous clear of `position`.
- `step_valid`  out  1  one-cycle pulse per decoded detent.
- `step_dir`  out  1  direction of the step, 1 = left, 0 = right. Valid only with `step_valid`.
- `position`  out  CNT_W  signed detent count.
- `push_level`  out  1  debounced push button level.
- `push_pulse`  out  1  one-cycle pulse on the debounced rising edge of push.
- `err_pulse`  out  1  one-cycle pulse on an illegal quadrature transition.

## Operation
- **Synchroniser:** each of `enc_a`, `enc_b` and `enc_push` passes through its own 2-flop synchroniser.
- **Debounce (per input):**
  - A counter tracks how long the synchronised value has differed from the debounced value.
  - When the two agree, the counter is zero.
  - When they differ for DEB_CYCLES consecutive clocks, the debounced value takes the synchronised value at the next edge and the counter clears.
  - A glitch shorter than DEB_CYCLES never propagates.
- **Quadrature FSM:** the state is the debounced {A,B}. Four states: S00, S01, S11, S10. An `armed` flag is held alongside the state.
  - Entering S00 sets `armed`.
  - S01→S11 with `armed`: `step_valid`=1, `step_dir`=1, `armed` cleared.
  - S10→S11 with `armed`: `step_valid`=1, `step_dir`=0, `armed` cleared.
  - Any other single-bit change: state follows, no event.
  - Both bits changing in one clock (S00↔S11, S01↔S10): `err_pulse`=1, state follows, `armed` cleared, no step.
  - Reversal mid-detent: e.g. S00→S01→S00 produces no step, and `armed` stays set.
- **Position:**
  - On a step, `position` is incremented for dir=0 and decremented for dir=1.
  - Arithmetic is two's-complement modulo 2^CNT_W: 0x7FFF+1 wraps to 0x8000 (CNT_W=16), and 0x0000−1 gives 0xFFFF.
  - `pos_clr` forces `position` to 0 at the next edge.
  - `pos_clr` and a step in the same cycle: the clear wins and the step is lost from the count, but `step_valid` is still emitted.
- **Push:** `push_level` is the debounced button level. `push_pulse` fires for one clock when `push_level` goes 0→1. There is no pulse on release.

## Timing
- **Reset values:** `step_valid`, `step_dir`, `err_pulse`, `push_pulse`, `push_level` = 0; `position` = 0.
- **State held in reset:** synchronisers and debounced values = 0, FSM = S00, `armed` = 1, debounce counters = 0.
- **Reset mid-operation:** asserting `rst_n` low clears all of the above immediately (asynchronously), with no event emitted. After release, inputs already at 1 take DEB_CYCLES+2 clocks to be accepted.
- **Step latency:** from a clean pin edge (setup met) to `step_valid` high is 2 (sync) + DEB_CYCLES (filter) + 1 (FSM register) = DEB_CYCLES+3 clocks.
- **Position latency:** `position` reflects the step in the same cycle that `step_valid` is high, since both are registered together.
- **Push latency:** `push_pulse` appears DEB_CYCLES+3 clocks after the press edge.
- **Event spacing:** all pulses are exactly one clock wide. Consecutive steps are at least 2×DEB_CYCLES apart by construction.

## Structure
- **Package `rotary_pkg`:**
  - State encodings ST_00, ST_01, ST_11, ST_10 as 2-bit constants equal to {A,B}.
  - DIR_LEFT = 1, DIR_RIGHT = 0.
  - Debounce counter width function: clog2(DEB_CYCLES+1).
- **Sub-module `debounce_filter`:**
  - Contains the 2-flop synchroniser plus the stable-count filter.
  - Parameter DEB_CYCLES; ports `clk`, `rst_n`, `din`, `dout`.
  - Instantiated three times (A, B, push).
- **Top level:** FSM, position counter and edge detect.

## Test plan
- **Clockwise detent (DEB_CYCLES=4):** drive {A,B} through 00→10→11→01→00, each held 10 clocks.
  - Expect exactly one `step_valid` with `step_dir`=0, 7 clocks after the 10→11 pin edge.
  - `position` goes from 0 to 1.
- **Counter-clockwise, three detents:** drive 00→01→11→10→00 three times from `position`=0.
  - Expect three pulses with `step_dir`=1.
  - `position` = 0xFFFD (CNT_W=16).
- **Bounce rejection:** toggle A for 3 clocks, five times, then hold it stable.
  - Expect no change in the debounced A during the bursts.
  - Expect a single step event after A is stable.
- **Illegal transition:** jump 00→11 in one clock.
  - Expect `err_pulse`=1, no `step_valid`, `position` unchanged.
  - A following 11→01→00→01→11 yields one step, because the entry to S00 re-arms the FSM.
- **Wrap and clear:**
  - Preload to 0x7FFF via 32767 right steps (or force), then one more right step: `position` = 0x8000.
  - `pos_clr` coincident with a step gives `position` = 0 with `step_valid` = 1.
- **Push and reset:**
  - Press held 20 clocks: one `push_pulse`; `push_level` = 1 until release + 7 clocks.
  - Assert `rst_n` low mid-press: all outputs 0 immediately, and no pulse after release of reset until the press is re-accepted.
